// File: rtl/uart_tx_fifo_engine.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo_engine : FIFO-buffered UART transmitter, internal baud divider
// Rev 1.0
// ============================================================================
module uart_tx_fifo_engine #(
  parameter int P_SYSTEM_CLK      = 100_000_000,
  parameter int P_UART_BUADRATE   = 115200,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0,
  parameter int P_FIFO_DEPTH      = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [P_UART_DATA_WIDTH-1:0]    i_user_tx_data,
  input  logic                            i_user_tx_valid,
  output logic                            o_user_tx_ready,
  output logic                            o_uart_tx,
  output logic                            o_tx_busy,
  output logic [$clog2(P_FIFO_DEPTH):0]   o_fifo_count
);

  localparam int C_BIT_LEN = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam int C_BAUD_W  = (C_BIT_LEN > 1) ? $clog2(C_BIT_LEN) : 1;
  localparam int C_ADDR_W  = $clog2(P_FIFO_DEPTH);
  localparam int C_CNT_W   = C_ADDR_W + 1;
  localparam int C_BIT_W   = $clog2(P_UART_DATA_WIDTH);

  localparam logic [C_BAUD_W-1:0] C_BAUD_LAST = C_BAUD_W'(C_BIT_LEN - 1);
  localparam logic [C_BIT_W-1:0]  C_DATA_LAST = C_BIT_W'(P_UART_DATA_WIDTH - 1);
  localparam logic [C_BIT_W-1:0]  C_STOP_LAST = C_BIT_W'(P_UART_STOP_WIDTH - 1);
  localparam logic [C_CNT_W-1:0]  C_DEPTH     = C_CNT_W'(P_FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic [C_BAUD_W-1:0]            baud_q, baud_d;
  logic [C_BIT_W-1:0]             bit_q, bit_d;
  logic [P_UART_DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                           parity_q, parity_d;
  logic                           tx_q, tx_d;
  logic                           busy_q, busy_d;
  logic [C_ADDR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [C_ADDR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0]             count_q, count_d;
  logic                           ready_q, ready_d;
  logic [P_UART_DATA_WIDTH-1:0]   mem_q [P_FIFO_DEPTH];

  logic                           w_push;
  logic                           w_load;
  logic                           w_baud_end;
  logic [P_UART_DATA_WIDTH-1:0]   w_head;

  assign w_push     = i_user_tx_valid && ready_q;
  assign w_baud_end = (baud_q == C_BAUD_LAST);
  assign w_head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + C_BAUD_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    w_load   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        w_load = (count_q != '0);
      end
      ST_START: begin
        if (w_baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (w_baud_end) begin
          baud_d = '0;
          if (bit_q == C_DATA_LAST) begin
            bit_d = '0;
            if (P_UART_CHECK != 0) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + C_BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (w_baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_baud_end) begin
          baud_d = '0;
          if (bit_q == C_STOP_LAST) begin
            bit_d   = '0;
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            w_load  = (count_q != '0);
          end else begin
            bit_d = bit_q + C_BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // Loading from STOP skips IDLE entirely so frames abut with no gap.
    if (w_load) begin
      shift_d  = w_head;
      parity_d = (P_UART_CHECK == 1) ? ~(^w_head) : (^w_head);
      state_d  = ST_START;
      tx_d     = 1'b0;
      baud_d   = '0;
      bit_d    = '0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + C_ADDR_W'(w_push);
    rd_ptr_d = rd_ptr_q + C_ADDR_W'(w_load);
    count_d  = count_q;
    if (w_push && !w_load) begin
      count_d = count_q + C_CNT_W'(1);
    end else if (!w_push && w_load) begin
      count_d = count_q - C_CNT_W'(1);
    end
    ready_d = (count_d != C_DEPTH);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= i_user_tx_data;
    end
  end

  assign o_user_tx_ready = ready_q;
  assign o_uart_tx       = tx_q;
  assign o_tx_busy       = busy_q;
  assign o_fifo_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_engine.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo_engine : directed self-checking bench for uart_tx_fifo_engine
// Rev 1.0
// ============================================================================
module tb_uart_tx_fifo_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8N1, L=4, depth 16
  logic [7:0] d_nrm = '0;
  logic       v_nrm = 1'b0;
  logic       r_nrm, tx_nrm, b_nrm;
  logic [4:0] c_nrm;
  // 8O1, L=4
  logic [7:0] d_odd = '0;
  logic       v_odd = 1'b0;
  logic       r_odd, tx_odd, b_odd;
  logic [4:0] c_odd;
  // 8E1, L=4
  logic [7:0] d_evn = '0;
  logic       v_evn = 1'b0;
  logic       r_evn, tx_evn, b_evn;
  logic [4:0] c_evn;
  // 8N1, L=4, depth 4
  logic [7:0] d_ful = '0;
  logic       v_ful = 1'b0;
  logic       r_ful, tx_ful, b_ful;
  logic [2:0] c_ful;
  // 7N2, L=3
  logic [6:0] d_stp = '0;
  logic       v_stp = 1'b0;
  logic       r_stp, tx_stp, b_stp;
  logic [4:0] c_stp;

  uart_tx_fifo_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(250_000),
    .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0), .P_FIFO_DEPTH(16)) dut_nrm (
    .clock(clk), .reset(rst_n), .i_user_tx_data(d_nrm), .i_user_tx_valid(v_nrm),
    .o_user_tx_ready(r_nrm), .o_uart_tx(tx_nrm), .o_tx_busy(b_nrm), .o_fifo_count(c_nrm));

  uart_tx_fifo_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(250_000),
    .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1), .P_FIFO_DEPTH(16)) dut_odd (
    .clock(clk), .reset(rst_n), .i_user_tx_data(d_odd), .i_user_tx_valid(v_odd),
    .o_user_tx_ready(r_odd), .o_uart_tx(tx_odd), .o_tx_busy(b_odd), .o_fifo_count(c_odd));

  uart_tx_fifo_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(250_000),
    .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2), .P_FIFO_DEPTH(16)) dut_evn (
    .clock(clk), .reset(rst_n), .i_user_tx_data(d_evn), .i_user_tx_valid(v_evn),
    .o_user_tx_ready(r_evn), .o_uart_tx(tx_evn), .o_tx_busy(b_evn), .o_fifo_count(c_evn));

  uart_tx_fifo_engine #(.P_SYSTEM_CLK(1_000_000), .P_UART_BUADRATE(250_000),
    .P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0), .P_FIFO_DEPTH(4)) dut_ful (
    .clock(clk), .reset(rst_n), .i_user_tx_data(d_ful), .i_user_tx_valid(v_ful),
    .o_user_tx_ready(r_ful), .o_uart_tx(tx_ful), .o_tx_busy(b_ful), .o_fifo_count(c_ful));

  uart_tx_fifo_engine #(.P_SYSTEM_CLK(300_000), .P_UART_BUADRATE(100_000),
    .P_UART_DATA_WIDTH(7), .P_UART_STOP_WIDTH(2), .P_UART_CHECK(0), .P_FIFO_DEPTH(16)) dut_stp (
    .clock(clk), .reset(rst_n), .i_user_tx_data(d_stp), .i_user_tx_valid(v_stp),
    .o_user_tx_ready(r_stp), .o_uart_tx(tx_stp), .o_tx_busy(b_stp), .o_fifo_count(c_stp));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample lines and busy flags once per cycle, starting with the current cycle.
  task automatic capture(input int n, output logic [255:0] w_nrm, output logic [255:0] w_odd,
                         output logic [255:0] w_evn, output logic [255:0] w_stp,
                         output logic [255:0] wb_nrm, output logic [255:0] wb_stp);
    w_nrm = '0; w_odd = '0; w_evn = '0; w_stp = '0; wb_nrm = '0; wb_stp = '0;
    for (int k = 0; k < n; k++) begin
      w_nrm[k]  = tx_nrm;
      w_odd[k]  = tx_odd;
      w_evn[k]  = tx_evn;
      w_stp[k]  = tx_stp;
      wb_nrm[k] = b_nrm;
      wb_stp[k] = b_stp;
      step();
    end
  endtask

  // Stretch a hand-written frame (bit 0 sent first) to l clocks per bit.
  function automatic logic [255:0] expand(input logic [255:0] base, input logic [15:0] bits,
                                          input int nbits, input int l, input int offset);
    for (int b = 0; b < nbits; b++)
      for (int j = 0; j < l; j++)
        base[offset + b*l + j] = bits[b];
    return base;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (tx_nrm !== 1'b1) begin errors++; $display("FAIL reset_line got %b exp 1", tx_nrm); end
    checks++; if (b_nrm !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", b_nrm); end
    checks++; if (c_nrm !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", c_nrm); end
    checks++; if (r_nrm !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", r_nrm); end
    checks++; if (r_ful !== 1'b1 || tx_ful !== 1'b1) begin errors++;
      $display("FAIL reset_ful got ready %b line %b exp 1 1", r_ful, tx_ful); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_frame();
    logic [255:0] w, wo, we, ws, wb, wbs, ex;
    d_nrm = 8'hA5; v_nrm = 1'b1;
    step();
    v_nrm = 1'b0;
    checks++; if (c_nrm !== 5'd1) begin errors++; $display("FAIL a5_count_after_accept got %0d exp 1", c_nrm); end
    checks++; if (tx_nrm !== 1'b1) begin errors++; $display("FAIL a5_line_before_start got %b exp 1", tx_nrm); end
    step();
    capture(41, w, wo, we, ws, wb, wbs);
    ex = expand('0, 16'({1'b1, 8'hA5, 1'b0}), 10, 4, 0);
    for (int k = 0; k < 40; k++) begin
      checks++; if (w[k] !== ex[k]) begin errors++; $display("FAIL a5_line[%0d] got %b exp %b", k, w[k], ex[k]); end
      checks++; if (wb[k] !== 1'b1) begin errors++; $display("FAIL a5_busy[%0d] got %b exp 1", k, wb[k]); end
    end
    checks++; if (w[40] !== 1'b1 || wb[40] !== 1'b0) begin errors++;
      $display("FAIL a5_after_frame got line %b busy %b exp 1 0", w[40], wb[40]); end
  endtask

  task automatic test_parity();
    logic [255:0] wn, wo, we, ws, wb, wbs, ex_o, ex_e;
    logic [7:0] vals [2];
    logic [1:0] par_o, par_e;
    vals[0] = 8'h07; vals[1] = 8'h00;
    par_o = 2'b10;  // 0x07 -> 0, 0x00 -> 1
    par_e = 2'b01;  // 0x07 -> 1, 0x00 -> 0
    for (int t = 0; t < 2; t++) begin
      d_odd = vals[t]; d_evn = vals[t]; v_odd = 1'b1; v_evn = 1'b1;
      step();
      v_odd = 1'b0; v_evn = 1'b0;
      step();
      capture(45, wn, wo, we, ws, wb, wbs);
      ex_o = expand('0, 16'({1'b1, par_o[t], vals[t], 1'b0}), 11, 4, 0);
      ex_e = expand('0, 16'({1'b1, par_e[t], vals[t], 1'b0}), 11, 4, 0);
      for (int k = 0; k < 45; k++) begin
        if (k == 44) begin ex_o[k] = 1'b1; ex_e[k] = 1'b1; end
        checks++; if (wo[k] !== ex_o[k]) begin errors++;
          $display("FAIL odd_line_%02h[%0d] got %b exp %b", vals[t], k, wo[k], ex_o[k]); end
        checks++; if (we[k] !== ex_e[k]) begin errors++;
          $display("FAIL even_line_%02h[%0d] got %b exp %b", vals[t], k, we[k], ex_e[k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] w, wo, we, ws, wb, wbs, ex;
    d_nrm = 8'h01; v_nrm = 1'b1;
    step();
    checks++; if (c_nrm !== 5'd1) begin errors++; $display("FAIL b2b_count1 got %0d exp 1", c_nrm); end
    d_nrm = 8'h02;
    step();
    checks++; if (c_nrm !== 5'd1) begin errors++; $display("FAIL b2b_count2 got %0d exp 1", c_nrm); end
    checks++; if (tx_nrm !== 1'b0) begin errors++; $display("FAIL b2b_start got %b exp 0", tx_nrm); end
    d_nrm = 8'h03;
    step();
    v_nrm = 1'b0;
    checks++; if (c_nrm !== 5'd2) begin errors++; $display("FAIL b2b_count_peak got %0d exp 2", c_nrm); end
    capture(120, w, wo, we, ws, wb, wbs);
    ex = expand('0, 16'({1'b1, 8'h01, 1'b0}), 10, 4, 0);
    ex = expand(ex, 16'({1'b1, 8'h02, 1'b0}), 10, 4, 40);
    ex = expand(ex, 16'({1'b1, 8'h03, 1'b0}), 10, 4, 80);
    for (int k = 0; k < 119; k++) begin
      checks++; if (w[k] !== ex[k+1]) begin errors++;
        $display("FAIL b2b_line[%0d] got %b exp %b", k + 1, w[k], ex[k+1]); end
      checks++; if (wb[k] !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got %b exp 1", k + 1, wb[k]); end
    end
    checks++; if (w[119] !== 1'b1 || wb[119] !== 1'b0 || c_nrm !== 5'd0) begin errors++;
      $display("FAIL b2b_end got line %b busy %b count %0d exp 1 0 0", w[119], wb[119], c_nrm); end
  endtask

  task automatic test_fifo_full();
    logic [255:0] w, ex;
    logic [7:0] bytes [6];
    int acc [6];
    int i;
    int exp_acc [6];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
    exp_acc[0] = 1; exp_acc[1] = 2; exp_acc[2] = 3; exp_acc[3] = 4; exp_acc[4] = 5; exp_acc[5] = 43;
    w = '0; ex = '0; i = 0;
    for (int q = 0; q < 6; q++) acc[q] = -1;
    for (int c = 0; c < 244; c++) begin
      if (c >= 2 && c < 242) w[c-2] = tx_ful;
      if (c == 5) begin
        checks++; if (r_ful !== 1'b0 || c_ful !== 3'd4) begin errors++;
          $display("FAIL full_at5 got ready %b count %0d exp 0 4", r_ful, c_ful); end
      end
      if (c == 41) begin
        checks++; if (r_ful !== 1'b0) begin errors++; $display("FAIL full_at41 got ready %b exp 0", r_ful); end
      end
      if (c == 42) begin
        checks++; if (r_ful !== 1'b1 || c_ful !== 3'd3) begin errors++;
          $display("FAIL full_at42 got ready %b count %0d exp 1 3", r_ful, c_ful); end
      end
      if (c == 242) begin
        checks++; if (tx_ful !== 1'b1 || c_ful !== 3'd0 || b_ful !== 1'b0) begin errors++;
          $display("FAIL full_end got line %b count %0d busy %b exp 1 0 0", tx_ful, c_ful, b_ful); end
      end
      if (i < 6) begin d_ful = bytes[i]; v_ful = 1'b1; end
      else v_ful = 1'b0;
      if (v_ful && r_ful) begin acc[i] = c + 1; i++; end
      step();
    end
    v_ful = 1'b0;
    for (int q = 0; q < 6; q++) begin
      checks++; if (acc[q] !== exp_acc[q]) begin errors++;
        $display("FAIL full_accept_edge[%0d] got %0d exp %0d", q, acc[q], exp_acc[q]); end
    end
    for (int q = 0; q < 6; q++) ex = expand(ex, 16'({1'b1, bytes[q], 1'b0}), 10, 4, q*40);
    for (int k = 0; k < 240; k++) begin
      checks++; if (w[k] !== ex[k]) begin errors++; $display("FAIL full_line[%0d] got %b exp %b", k, w[k], ex[k]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [255:0] w, wo, we, ws, wb, wbs, ex;
    d_nrm = 8'hC3; v_nrm = 1'b1;
    step();
    d_nrm = 8'h11;
    step();
    d_nrm = 8'h22;
    step();
    v_nrm = 1'b0;
    repeat (16) step();
    checks++; if (tx_nrm !== 1'b0 || c_nrm !== 5'd2) begin errors++;
      $display("FAIL mid_bit3 got line %b count %0d exp 0 2", tx_nrm, c_nrm); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++; if (tx_nrm !== 1'b1) begin errors++; $display("FAIL mid_reset_line got %b exp 1", tx_nrm); end
    checks++; if (b_nrm !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b exp 0", b_nrm); end
    checks++; if (c_nrm !== 5'd0) begin errors++; $display("FAIL mid_reset_count got %0d exp 0", c_nrm); end
    checks++; if (r_nrm !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b exp 1", r_nrm); end
    step();
    checks++; if (tx_nrm !== 1'b1 || b_nrm !== 1'b0) begin errors++;
      $display("FAIL mid_reset_idle got line %b busy %b exp 1 0", tx_nrm, b_nrm); end
    d_nrm = 8'h55; v_nrm = 1'b1;
    step();
    v_nrm = 1'b0;
    step();
    capture(41, w, wo, we, ws, wb, wbs);
    ex = expand('0, 16'({1'b1, 8'h55, 1'b0}), 10, 4, 0);
    ex[40] = 1'b1;
    for (int k = 0; k < 41; k++) begin
      checks++; if (w[k] !== ex[k]) begin errors++; $display("FAIL post_reset_line[%0d] got %b exp %b", k, w[k], ex[k]); end
    end
    checks++; if (wb[39] !== 1'b1 || wb[40] !== 1'b0) begin errors++;
      $display("FAIL post_reset_busy got %b %b exp 1 0", wb[39], wb[40]); end
  endtask

  task automatic test_two_stop();
    logic [255:0] wn, wo, we, w, wb, wbs, ex;
    d_stp = 7'h7F; v_stp = 1'b1;
    step();
    v_stp = 1'b0;
    step();
    capture(31, wn, wo, we, w, wb, wbs);
    ex = expand('0, 16'({2'b11, 7'h7F, 1'b0}), 10, 3, 0);
    ex[30] = 1'b1;
    for (int k = 0; k < 31; k++) begin
      checks++; if (w[k] !== ex[k]) begin errors++; $display("FAIL stop2_line[%0d] got %b exp %b", k, w[k], ex[k]); end
    end
    checks++; if (wbs[0] !== 1'b1 || wbs[29] !== 1'b1 || wbs[30] !== 1'b0) begin errors++;
      $display("FAIL stop2_busy got %b %b %b exp 1 1 0", wbs[0], wbs[29], wbs[30]); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_frame();
    test_two_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
